fetch_unit: RTL and testbench

Instruction fetch stage: owns the program counter, issues word-aligned requests to instruction memory, and buffers returned instruction words with their PCs for the decode stage. It sits directly upstream of decode, which consumes `out_instr` and `out_pc` through a valid/ready handshake. Branch and jump redirects from execute flush the stage and restart fetch at the new PC. In-flight stale responses are discarded.

---
 rtl/fetch_unit.sv | 112 +++++++++++
 tb/tb_fetch_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC ownership, credit-limited imem requests, {instr, pc} buffer for decode.
// Define FETCH_BYPASS_EN to present a response on out_* in its arrival cycle when the buffer is empty.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 1;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   r_pc;
  logic [31:0]   r_buf_instr [DEPTH];
  logic [31:0]   r_buf_pc    [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rq_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_discard;

  logic w_credit;
  logic w_req_fire;
  logic w_rsp_live;
  logic w_rsp_drop;
  logic w_byp;
  logic w_pop;
  logic w_buf_pop;
  logic w_push;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    w_credit       = (SW'(r_inflight) + SW'(r_count)) < SW'(DEPTH);
    imem_req_valid = !rst && !redirect_valid && w_credit;
    imem_req_addr  = r_pc;
    w_req_fire     = imem_req_valid && imem_req_ready;
    w_rsp_live     = imem_rsp_valid && (r_discard == '0);
    w_rsp_drop     = imem_rsp_valid && (r_discard != '0);
`ifdef FETCH_BYPASS_EN
    w_byp          = w_rsp_live && (r_count == '0);
`else
    w_byp          = 1'b0;
`endif
    out_valid      = ((r_count != '0) || w_byp) && !redirect_valid;
    out_instr      = '0;
    out_pc         = '0;
    // With an empty buffer rd_ptr == wr_ptr, so the reserved tag slot serves the bypassed word too
    if (out_valid) begin
      out_instr = w_byp ? imem_rsp_data : r_buf_instr[r_rd_ptr];
      out_pc    = r_buf_pc[r_rd_ptr];
    end
    w_pop          = out_valid && out_ready;
    w_buf_pop      = w_pop && !w_byp;
    w_push         = w_rsp_live && !(w_byp && w_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_rq_ptr   <= '0;
      r_count    <= '0;
      r_inflight <= '0;
      r_discard  <= '0;
    end else begin
      r_inflight <= r_inflight + CW'(w_req_fire) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        r_pc      <= redirect_pc & ~32'h3;
        r_rd_ptr  <= '0;
        r_wr_ptr  <= '0;
        r_rq_ptr  <= '0;
        r_count   <= '0;
        r_discard <= r_inflight - CW'(imem_rsp_valid);
      end else begin
        if (w_req_fire) begin
          r_pc     <= r_pc + 32'd4;
          r_rq_ptr <= f_inc(r_rq_ptr);
        end
        if (w_rsp_live) r_wr_ptr <= f_inc(r_wr_ptr);
        if (w_pop)      r_rd_ptr <= f_inc(r_rd_ptr);
        r_count   <= r_count + CW'(w_push) - CW'(w_buf_pop);
        r_discard <= r_discard - CW'(w_rsp_drop);
      end
    end
  end

  // Tag is reserved in the slot at request time; the word lands in the same slot on response
  always_ff @(posedge clk) begin
    if (!rst && !redirect_valid) begin
      if (w_req_fire) r_buf_pc[r_rq_ptr]    <= r_pc;
      if (w_push)     r_buf_instr[r_wr_ptr] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order latency memory model plus a program-order PC/instruction reference.
module tb_fetch_unit;
  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam int          DEPTH = 2;
`ifdef FETCH_BYPASS_EN
  localparam int FIRST_VALID = 1;
`else
  localparam int FIRST_VALID = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          n_pop = 0;
  int unsigned lat_min = 1;
  int unsigned lat_max = 1;
  int unsigned rdy_pct = 100;
  logic [31:0] exp_out_pc = RPC;
  logic [31:0] exp_req_pc = RPC;
  logic [31:0] qa[$];
  int          qd[$];

  fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_pop(input string tag, input logic [31:0] exp);
    int k;
    k = 0;
    @(negedge clk);
    while (!(out_valid && out_ready) && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_timeout"}, k < 60, 1);
    chk(tag, out_pc, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory: in-order responses, each no earlier than its due cycle
  always @(posedge clk) begin
    #1;
    imem_req_ready = ($urandom_range(0, 99) < rdy_pct);
    if (qa.size() > 0 && qd[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memf(qa[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      qa.delete();
      qd.delete();
      exp_out_pc = RPC;
      exp_req_pc = RPC;
    end else begin
      if (imem_rsp_valid) begin
        void'(qa.pop_front());
        void'(qd.pop_front());
      end
      if (redirect_valid) begin
        chk("redir_out_valid", out_valid, 0);
        chk("redir_req_valid", imem_req_valid, 0);
        exp_out_pc = redirect_pc & ~32'h3;
        exp_req_pc = redirect_pc & ~32'h3;
      end else begin
        if (out_valid && out_ready) begin
          chk("out_pc", out_pc, exp_out_pc);
          chk("out_instr", out_instr, memf(exp_out_pc));
          exp_out_pc = exp_out_pc + 32'd4;
          n_pop++;
        end
        if (imem_req_valid && imem_req_ready) begin
          chk("req_addr", imem_req_addr, exp_req_pc);
          exp_req_pc = exp_req_pc + 32'd4;
          qa.push_back(imem_req_addr);
          qd.push_back(cyc + int'($urandom_range(lat_min, lat_max)));
        end
      end
      chk("credit", qa.size() <= DEPTH, 1);
    end
  end

  initial begin
    int k;
    int p0;

    repeat (3) step();
    @(negedge clk);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_req_addr", imem_req_addr, RPC);

    step();
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("c0_req_valid", imem_req_valid, 1);
    chk("c0_req_addr", imem_req_addr, RPC);
    k = 0;
    while (!out_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("first_valid_cycle", k, FIRST_VALID);

    p0 = n_pop;
    repeat (20) step();
    chk("straight_progress", (n_pop - p0) >= 10, 1);

    out_ready = 1'b0;
    repeat (5) step();
    @(negedge clk);
    chk("bp_req_valid", imem_req_valid, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_out_pc", out_pc, exp_out_pc);
    step();
    out_ready = 1'b1;
    repeat (6) step();

    lat_min = 3;
    lat_max = 3;
    k = 0;
    while (qa.size() != 2 && k < 30) begin
      step();
      k++;
    end
    chk("rd2_reach", k < 30, 1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_2000;
    step();
    redirect_valid = 1'b0;
    wait_pop("rd2_first", 32'h0000_2000);
    wait_pop("rd2_second", 32'h0000_2004);

    step();
    lat_min   = 1;
    lat_max   = 1;
    out_ready = 1'b0;
    k = 0;
    while (!out_valid && k < 30) begin
      step();
      k++;
    end
    chk("rdh_pre_valid", out_valid, 1);
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3000;
    step();
    redirect_valid = 1'b0;
    wait_pop("rdh_first", 32'h0000_3000);

    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    step();
    redirect_valid = 1'b0;
    wait_pop("wrap_0", 32'hFFFF_FFFC);
    wait_pop("wrap_1", 32'h0000_0000);

    step();
    lat_min = 3;
    lat_max = 3;
    k = 0;
    while (qa.size() != 2 && k < 30) begin
      step();
      k++;
    end
    chk("rst2_reach", k < 30, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst2_req_valid_comb", imem_req_valid, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_out_instr", out_instr, 32'h0);
    chk("rst2_out_pc", out_pc, 32'h0);
    chk("rst2_req_valid", imem_req_valid, 1);
    chk("rst2_req_addr", imem_req_addr, RPC);
    wait_pop("rst2_first", RPC);

    lat_min = 1;
    lat_max = 4;
    rdy_pct = 70;
    repeat (1500) begin
      step();
      out_ready      = ($urandom_range(0, 99) < 70);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = $urandom;
      rst            = ($urandom_range(0, 299) == 0);
    end

    step();
    rst            = 1'b0;
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    rdy_pct        = 100;
    p0 = n_pop;
    repeat (30) step();
    chk("drain_progress", (n_pop - p0) >= 10, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
